button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Conditions the four raw resistor-ladder joystick lines before the direction decoder.
//  Per line: synchronise to clk, then debounce on a slow sample tick.
//  Outputs keep raw line polarity; direction decoding consumes db_out unchanged.
//  Also emits one-cycle press/release events for menu/restart logic.
// PARAMETERS
//  N_CH          4       number of input lines
//  SYNC_STAGES   2       synchroniser flops per line (>=2)
//  TICK_DIV      50000   clk cycles per sample tick (1 ms at 50 MHz), >=2
//  STABLE_TICKS  10      consecutive mismatching ticks required to accept a new level, >=1
//  IDLE_MASK     4'b1010 released level per line (one_resistor_* idle high, two_resistors_* idle low)
// PORTS
//  clk          in   1     system clock
//  rst_n        in   1     synchronous reset, active low
//  raw_in       in   N_CH  async lines: [3]=one_resistor_x [2]=two_resistors_x [1]=one_resistor_y [0]=two_resistors_y
//  db_out       out  N_CH  debounced levels, raw polarity
//  pressed      out  N_CH  active-bit vector: db_out ^ IDLE_MASK
//  press_evt    out  N_CH  1-cycle pulse: line moved idle->active
//  release_evt  out  N_CH  1-cycle pulse: line moved active->idle
//  tick         out  1     sample-tick strobe (1 cycle every TICK_DIV clocks)
// BEHAVIOUR
//  - Synchronous active-low reset, evaluated at posedge clk while rst_n==0:
//    - sync chain and db_out <= IDLE_MASK; pressed=0; press_evt=0; release_evt=0.
//    - prescaler=0; tick=0; all channel counters=0.
//  - Prescaler counts 0..TICK_DIV-1, then wraps to 0.
//    - tick=1 exactly in the cycle after the count equals TICK_DIV-1 (registered).
//  - Sync chain: sync[i] = raw_in[i] delayed SYNC_STAGES clocks; no logic between stages.
//  - Channel i, evaluated only in cycles where tick==1:
//    - sync[i]==db_out[i]: cnt[i] <= 0 (any bounce restarts qualification).
//    - sync[i]!=db_out[i] and cnt[i]<STABLE_TICKS-1: cnt[i] <= cnt[i]+1.
//    - sync[i]!=db_out[i] and cnt[i]==STABLE_TICKS-1: db_out[i] <= sync[i]; cnt[i] <= 0; fire event.
//  - Between ticks, cnt[i] and db_out[i] hold regardless of sync[i].
//  - Counter width: $clog2(STABLE_TICKS+1); cnt never exceeds STABLE_TICKS-1; no wrap.
//  - Events are registered in the same edge as the db_out update:
//    - press_evt[i]=1 if the new level is ~IDLE_MASK[i]; otherwise release_evt[i]=1.
//    - Both events are high for exactly that one cycle.
//  - Latency: a clean edge is accepted on the STABLE_TICKS-th tick after it reaches sync.
//    - Total: SYNC_STAGES + (STABLE_TICKS-1)*TICK_DIV + 1 .. SYNC_STAGES + STABLE_TICKS*TICK_DIV clocks.
//  - Channels are independent; several may update and pulse in the same cycle.
//  - Glitch shorter than one tick period that falls between ticks: invisible.
//  - Reset asserted mid-qualification: counters cleared, db_out forced idle, no event pulses.
//    - After release, lines already held active re-qualify from zero.
// STRUCTURE
//  - Shared definitions header: channel index constants (CH_ONE_RES_X etc.) and IDLE_MASK default.
//  - Sub-module debounce_channel: sync chain + cnt + db bit + evt pulses; shared tick input.
//  - Top: prescaler + generate loop of N_CH debounce_channel instances.
// TESTING (bench overrides: TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2)
//  1 Reset: hold rst_n=0 5 cycles with raw_in=4'b0101 -> db_out=4'b1010, pressed=0, no events, tick=0.
//  2 Clean press: raw_in[2] 0->1 held -> db_out[2]=1 and press_evt[2] 1-cycle pulse.
//    - Pulse lands within 2+8+1..2+12 clocks (11..14); pressed=4'b0100.
//  3 Bounce: raw_in[0] toggles 1/0 every 5 clocks for 40 clocks, then held 1.
//    - No event during the bounce; one press_evt[0] 9..12 clocks after sync settles.
//  4 Release on active-low line: raw_in[3] 1->0 -> press_evt[3]; then 0->1 -> release_evt[3].
//    - db_out[3] returns to 1 (idle).
//  5 Simultaneous: raw_in[1] and raw_in[0] change in the same cycle.
//    - press_evt[1] and press_evt[0] both fire in the same cycle.
//  6 Reset mid-qualification: rst_n=0 after 2 accepted ticks with raw_in[2]=1 held.
//    - No event during reset; after release, press_evt[2] needs a full 3 new ticks.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the joystick line debouncer: line indices, idle levels,
// and helpers used by the top and the per-line channel.
package button_debouncer_pkg;

    // Number of resistor-ladder joystick lines.
    localparam int unsigned NUM_LINES = 4;

    // Bit positions of each joystick line within raw_in / db_out.
    localparam int unsigned CH_TWO_RES_Y = 0;
    localparam int unsigned CH_ONE_RES_Y = 1;
    localparam int unsigned CH_TWO_RES_X = 2;
    localparam int unsigned CH_ONE_RES_X = 3;

    // Released (idle) level of each line type.
    localparam logic IDLE_ONE_RES = 1'b1;
    localparam logic IDLE_TWO_RES = 1'b0;

    // Released level per line, assembled from the line map (evaluates to 4'b1010).
    localparam logic [NUM_LINES-1:0] IDLE_MASK_DEFAULT =
        (NUM_LINES'(IDLE_ONE_RES) << CH_ONE_RES_X) |
        (NUM_LINES'(IDLE_TWO_RES) << CH_TWO_RES_X) |
        (NUM_LINES'(IDLE_ONE_RES) << CH_ONE_RES_Y) |
        (NUM_LINES'(IDLE_TWO_RES) << CH_TWO_RES_Y);

    // Width of a qualification counter that must hold values 0..ticks.
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: synchroniser chain, tick-qualified stability counter,
// debounced level and one-cycle press/release pulses.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_TICKS = 10,
    parameter logic        IDLE_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic db,
    output logic press_evt,
    output logic release_evt
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    // Plain shift chain; the oldest stage is the synchronised level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

    // Qualify a new level over consecutive mismatching ticks; any match restarts.
    always_comb begin
        cnt_d     = cnt_q;
        db_d      = db_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            if (sync_level == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                db_d  = sync_level;
                if (sync_level != IDLE_LEVEL) begin
                    press_d = 1'b1;
                end else begin
                    release_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter, debounced level and event pulses; reset forces idle with no pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            db_q      <= IDLE_LEVEL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign db          = db_q;
    assign press_evt   = press_q;
    assign release_evt = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Joystick line conditioner: shared sample-tick prescaler feeding one debounce
// channel per raw line. Outputs keep raw polarity; pressed is relative to idle.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned     N_CH         = NUM_LINES,
    parameter int unsigned     SYNC_STAGES  = 2,
    parameter int unsigned     TICK_DIV     = 50000,
    parameter int unsigned     STABLE_TICKS = 10,
    parameter logic [N_CH-1:0] IDLE_MASK    = N_CH'(IDLE_MASK_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] press_evt,
    output logic [N_CH-1:0] release_evt,
    output logic            tick
);

    localparam int unsigned     PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    // Prescaler wraps at TICK_DIV-1; the strobe is registered off the wrap.
    always_comb begin
        pre_d  = pre_q + PRE_W'(1);
        tick_d = 1'b0;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Prescaler and tick strobe registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        button_debouncer_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .IDLE_LEVEL   (IDLE_MASK[i])
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (raw_in[i]),
            .tick        (tick_q),
            .db          (db_out[i]),
            .press_evt   (press_evt[i]),
            .release_evt (release_evt[i])
        );
    end

    assign pressed = db_out ^ IDLE_MASK;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2.
module tb_button_debouncer;
    import button_debouncer_pkg::*;

    localparam int TD  = 4;
    localparam int ST  = 3;
    localparam int SS  = 2;
    localparam int INF = 32'h3fff_ffff;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] raw_in;
    logic [3:0] db_out;
    logic [3:0] pressed;
    logic [3:0] press_evt;
    logic [3:0] release_evt;
    logic       tick;

    int   cyc         = 0;
    int   rel_edge    = INF;  // first clock edge with rst_n high
    int   assert_edge = 0;    // first clock edge of a later reset
    int   n_checks    = 0;
    int   n_errors    = 0;
    exp_t sb[$];

    button_debouncer #(
        .N_CH         (4),
        .SYNC_STAGES  (SS),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .IDLE_MASK    (4'b1010)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_in),
        .db_out      (db_out),
        .pressed     (pressed),
        .press_evt   (press_evt),
        .release_evt (release_evt),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge at which an edge driven right after edge c0 gets accepted.
    function automatic int pred(input int c0);
        int t;
        t = c0 + SS + 1;
        if (t < rel_edge + TD) t = rel_edge + TD;
        while ((t - rel_edge) % TD != 0) t++;
        return t + (ST - 1) * TD;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input logic [3:0] p, input logic [3:0] r, input int c0);
        exp_t e;
        e.press = p;
        e.rel   = r;
        e.cyc   = pred(c0);
        sb.push_back(e);
    endtask

    task automatic check_state(input string name, input logic [3:0] exp_db,
                               input logic [3:0] exp_pr);
        n_checks++;
        if (db_out !== exp_db) begin
            n_errors++;
            $display("FAIL %s db_out: got %b want %b", name, db_out, exp_db);
        end
        n_checks++;
        if (pressed !== exp_pr) begin
            n_errors++;
            $display("FAIL %s pressed: got %b want %b", name, pressed, exp_pr);
        end
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if (press_evt !== 4'b0 || release_evt !== 4'b0 || tick !== 1'b0) begin
            n_errors++;
            $display("FAIL %s quiet: got press=%b rel=%b tick=%b want 0000 0000 0",
                     name, press_evt, release_evt, tick);
        end
    endtask

    // Monitor: tick phase every cycle, events popped from the scoreboard.
    always @(negedge clk) begin
        logic exp_tick;
        exp_t e;
        exp_tick = (cyc >= rel_edge) && (assert_edge <= rel_edge || cyc < assert_edge)
                   && ((cyc - rel_edge) % TD == TD - 1);
        n_checks++;
        if (tick !== exp_tick) begin
            n_errors++;
            $display("FAIL tick at cyc %0d: got %b want %b", cyc, tick, exp_tick);
        end
        if ((press_evt | release_evt) !== 4'b0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_evt at cyc %0d: got press=%b rel=%b want none",
                         cyc, press_evt, release_evt);
            end else begin
                e = sb.pop_front();
                if (press_evt !== e.press || release_evt !== e.rel || cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL evt: got press=%b rel=%b cyc=%0d want press=%b rel=%b cyc=%0d",
                             press_evt, release_evt, cyc, e.press, e.rel, e.cyc);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missing_evt: got none by cyc %0d want press=%b rel=%b at cyc %0d",
                     cyc, e.press, e.rel, e.cyc);
        end
    end

    initial begin
        int t1;
        rst_n  = 1'b0;
        raw_in = 4'b0101;

        // 1: reset with every line driven active
        step(5);
        check_state("reset", 4'b1010, 4'b0000);
        check_quiet("reset");
        raw_in   = 4'b1010;
        rst_n    = 1'b1;
        rel_edge = cyc + 1;
        step(10);
        check_state("idle", 4'b1010, 4'b0000);

        // 2: clean press on an idle-low line
        raw_in[CH_TWO_RES_X] = 1'b1;
        expect_evt(4'b0100, 4'b0000, cyc);
        step(20);
        check_state("clean_press", 4'b1110, 4'b0100);

        // 3: bounce then settle high
        for (int k = 0; k < 8; k++) begin
            raw_in[CH_TWO_RES_Y] = ~raw_in[CH_TWO_RES_Y];
            step(5);
        end
        raw_in[CH_TWO_RES_Y] = 1'b1;
        expect_evt(4'b0001, 4'b0000, cyc);
        step(20);
        check_state("bounce", 4'b1111, 4'b0101);

        // 4: active-low line pressed then released
        raw_in[CH_ONE_RES_X] = 1'b0;
        expect_evt(4'b1000, 4'b0000, cyc);
        step(20);
        check_state("low_press", 4'b0111, 4'b1101);
        raw_in[CH_ONE_RES_X] = 1'b1;
        expect_evt(4'b0000, 4'b1000, cyc);
        step(20);
        check_state("low_release", 4'b1111, 4'b0101);

        // 5: two lines change in the same cycle
        raw_in[CH_TWO_RES_Y] = 1'b0;
        expect_evt(4'b0000, 4'b0001, cyc);
        step(20);
        raw_in[CH_ONE_RES_Y] = 1'b0;
        raw_in[CH_TWO_RES_Y] = 1'b1;
        expect_evt(4'b0011, 4'b0000, cyc);
        step(20);
        check_state("simultaneous", 4'b1101, 4'b0111);

        // 6: release everything, then reset during a fresh qualification
        raw_in = 4'b1010;
        expect_evt(4'b0000, 4'b0111, cyc);
        step(20);
        check_state("all_idle", 4'b1010, 4'b0000);
        raw_in[CH_TWO_RES_X] = 1'b1;
        t1 = pred(cyc) - (ST - 1) * TD;
        while (cyc < t1 + TD) step(1);
        rst_n       = 1'b0;
        assert_edge = cyc + 1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check_state("mid_reset", 4'b1010, 4'b0000);
            check_quiet("mid_reset");
        end
        rst_n    = 1'b1;
        rel_edge = cyc + 1;
        expect_evt(4'b0100, 4'b0000, rel_edge - 1);
        step(20);
        check_state("requalify", 4'b1110, 4'b0100);

        step(5);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1000000 ns want finish");
        $fatal(1, "watchdog");
    end

endmodule
